// File: rtl/execute_pkg.sv
// Shared opcodes, FSM states and helpers for the execute stage
// and its iterative multiply/divide unit.
package execute_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_PASSB = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIV   = 4'd11,
    OP_MOD   = 4'd12
  } alu_op_t;

  localparam logic [3:0] ALU_MUL = OP_MUL;
  localparam logic [3:0] ALU_DIV = OP_DIV;
  localparam logic [3:0] ALU_MOD = OP_MOD;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_t;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op == ALU_MUL) ||
           (op == ALU_DIV) ||
           (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/execute_stage_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring
// divide; one iteration per cycle, DATA_W iterations total.
module muldiv_iter
  import execute_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int CW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [CW-1:0]     count,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              fits;
  logic              last;

  // p: product accumulator / partial remainder
  // x: shifted multiplicand / dividend-quotient shifter
  // y: multiplier (shifts right) / divisor (fixed)
  always_comb begin
    trial = {p_q, x_q[DATA_W-1]};
    fits  = trial >= {1'b0, y_q};
    diff  = trial[DATA_W-1:0] - y_q;
    last  = run_q && (cnt_q == CW'(DATA_W - 1));
    run_d = run_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    p_d   = p_q;
    x_d   = x_q;
    y_d   = y_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      op_d  = op;
      p_d   = '0;
      x_d   = a;
      y_d   = b;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        run_d = 1'b0;
      end
      if (op_q == ALU_MUL) begin
        if (y_q[0]) begin
          p_d = p_q + x_q;
        end
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end else begin
        p_d = fits ? diff : trial[DATA_W-1:0];
        x_d = {x_q[DATA_W-2:0], fits};
      end
    end
    if ((op_q == ALU_MUL) || (op_q == ALU_MOD)) begin
      result = p_d;
    end else begin
      result = x_d;
    end
  end

  assign count = cnt_q;
  assign done  = last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= '0;
      p_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      p_q   <= p_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and
// stall control around the iterative MUL/DIV/MOD unit.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        aluOp_execute,
  input  logic [DATA_W-1:0] srcA_in,
  input  logic [DATA_W-1:0] srcB_in,
  input  logic [REG_W-1:0]  rs1_execute,
  input  logic [REG_W-1:0]  rs2_execute,
  input  logic [REG_W-1:0]  rd_execute,
  input  logic              wre_execute,
  input  logic              write_memory_enable_execute,
  input  logic [1:0]        select_writeback_data_mux_execute,
  input  logic [REG_W-1:0]  rd_memory,
  input  logic              wre_memory,
  input  logic [DATA_W-1:0] result_memory,
  input  logic [REG_W-1:0]  rd_writeback,
  input  logic              wre_writeback,
  input  logic [DATA_W-1:0] result_writeback,
  output logic              stall_execute,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              wre_out,
  output logic              wme_out,
  output logic [1:0]        wb_sel_out
);

  localparam int CW = $clog2(DATA_W);

  ex_state_t         state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              wre_q, wre_d;
  logic              wme_q, wme_d;
  logic [1:0]        sel_q, sel_d;

  logic [DATA_W-1:0] cap_st_q, cap_st_d;
  logic [REG_W-1:0]  cap_rd_q, cap_rd_d;
  logic              cap_wre_q, cap_wre_d;
  logic              cap_wme_q, cap_wme_d;
  logic [1:0]        cap_sel_q, cap_sel_d;

  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic [DATA_W-1:0] alu_res;
  logic [CW-1:0]     shamt;
  logic              md_start;
  logic [CW-1:0]     md_count;
  logic              md_done;
  logic [DATA_W-1:0] md_result;

  // Memory stage wins over writeback; r0 is never forwarded.
  always_comb begin
    if (wre_memory && (rd_memory != '0) &&
        (rd_memory == rs1_execute)) begin
      fwd_a = result_memory;
    end else if (wre_writeback && (rd_writeback != '0) &&
                 (rd_writeback == rs1_execute)) begin
      fwd_a = result_writeback;
    end else begin
      fwd_a = srcA_in;
    end
  end

  always_comb begin
    if (wre_memory && (rd_memory != '0) &&
        (rd_memory == rs2_execute)) begin
      fwd_b = result_memory;
    end else if (wre_writeback && (rd_writeback != '0) &&
                 (rd_writeback == rs2_execute)) begin
      fwd_b = result_writeback;
    end else begin
      fwd_b = srcB_in;
    end
  end

  assign shamt = fwd_b[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (aluOp_execute)
      OP_ADD:   alu_res = fwd_a + fwd_b;
      OP_SUB:   alu_res = fwd_a - fwd_b;
      OP_AND:   alu_res = fwd_a & fwd_b;
      OP_OR:    alu_res = fwd_a | fwd_b;
      OP_XOR:   alu_res = fwd_a ^ fwd_b;
      OP_SLL:   alu_res = fwd_a << shamt;
      OP_SRL:   alu_res = fwd_a >> shamt;
      OP_SRA:   alu_res = $signed(fwd_a) >>> shamt;
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}},
                           $signed(fwd_a) < $signed(fwd_b)};
      OP_PASSB: alu_res = fwd_b;
      default:  alu_res = '0;
    endcase
  end

  assign md_start = (state_q == IDLE) &&
                    is_multicycle(aluOp_execute);

  muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (aluOp_execute),
    .a      (fwd_a),
    .b      (fwd_b),
    .count  (md_count),
    .done   (md_done),
    .result (md_result)
  );

  // Drops on the final iteration so upstream advances in
  // lock-step with the result being registered.
  assign stall_execute = reset && (md_start ||
    ((state_q == BUSY) && (md_count != CW'(DATA_W - 1))));

  always_comb begin
    state_d   = state_q;
    res_d     = '0;
    st_d      = '0;
    rd_d      = '0;
    wre_d     = 1'b0;
    wme_d     = 1'b0;
    sel_d     = '0;
    cap_st_d  = cap_st_q;
    cap_rd_d  = cap_rd_q;
    cap_wre_d = cap_wre_q;
    cap_wme_d = cap_wme_q;
    cap_sel_d = cap_sel_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d   = BUSY;
          cap_st_d  = fwd_b;
          cap_rd_d  = rd_execute;
          cap_wre_d = wre_execute;
          cap_wme_d = write_memory_enable_execute;
          cap_sel_d = select_writeback_data_mux_execute;
        end else begin
          res_d = alu_res;
          st_d  = fwd_b;
          rd_d  = rd_execute;
          wre_d = wre_execute;
          wme_d = write_memory_enable_execute;
          sel_d = select_writeback_data_mux_execute;
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = IDLE;
          res_d   = md_result;
          st_d    = cap_st_q;
          rd_d    = cap_rd_q;
          wre_d   = cap_wre_q;
          wme_d   = cap_wme_q;
          sel_d   = cap_sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      res_q     <= '0;
      st_q      <= '0;
      rd_q      <= '0;
      wre_q     <= 1'b0;
      wme_q     <= 1'b0;
      sel_q     <= '0;
      cap_st_q  <= '0;
      cap_rd_q  <= '0;
      cap_wre_q <= 1'b0;
      cap_wme_q <= 1'b0;
      cap_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      st_q      <= st_d;
      rd_q      <= rd_d;
      wre_q     <= wre_d;
      wme_q     <= wme_d;
      sel_q     <= sel_d;
      cap_st_q  <= cap_st_d;
      cap_rd_q  <= cap_rd_d;
      cap_wre_q <= cap_wre_d;
      cap_wme_q <= cap_wme_d;
      cap_sel_q <= cap_sel_d;
    end
  end

  assign result_out     = res_q;
  assign store_data_out = st_q;
  assign rd_out         = rd_q;
  assign wre_out        = wre_q;
  assign wme_out        = wme_q;
  assign wb_sel_out     = sel_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: forwarding,
// single-cycle ALU, iterative MUL/DIV/MOD timing and reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  aluOp_execute;
  logic [15:0] srcA_in, srcB_in;
  logic [3:0]  rs1_execute, rs2_execute, rd_execute;
  logic        wre_execute;
  logic        write_memory_enable_execute;
  logic [1:0]  select_writeback_data_mux_execute;
  logic [3:0]  rd_memory;
  logic        wre_memory;
  logic [15:0] result_memory;
  logic [3:0]  rd_writeback;
  logic        wre_writeback;
  logic [15:0] result_writeback;
  logic        stall_execute;
  logic [15:0] result_out, store_data_out;
  logic [3:0]  rd_out;
  logic        wre_out, wme_out;
  logic [1:0]  wb_sel_out;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] st;
    logic [3:0]  rd;
    logic        wre;
    logic        wme;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                               (clk),
    .reset                             (reset),
    .aluOp_execute                     (aluOp_execute),
    .srcA_in                           (srcA_in),
    .srcB_in                           (srcB_in),
    .rs1_execute                       (rs1_execute),
    .rs2_execute                       (rs2_execute),
    .rd_execute                        (rd_execute),
    .wre_execute                       (wre_execute),
    .write_memory_enable_execute       (write_memory_enable_execute),
    .select_writeback_data_mux_execute (select_writeback_data_mux_execute),
    .rd_memory                         (rd_memory),
    .wre_memory                        (wre_memory),
    .result_memory                     (result_memory),
    .rd_writeback                      (rd_writeback),
    .wre_writeback                     (wre_writeback),
    .result_writeback                  (result_writeback),
    .stall_execute                     (stall_execute),
    .result_out                        (result_out),
    .store_data_out                    (store_data_out),
    .rd_out                            (rd_out),
    .wre_out                           (wre_out),
    .wme_out                           (wme_out),
    .wb_sel_out                        (wb_sel_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] rs,
                                      input logic [15:0] rf);
    if (wre_memory && rd_memory != 4'd0 && rd_memory == rs)
      return result_memory;
    if (wre_writeback && rd_writeback != 4'd0 && rd_writeback == rs)
      return result_writeback;
    return rf;
  endfunction

  function automatic exp_t issue_exp(input logic [15:0] res);
    exp_t e;
    e.res = res;
    e.st  = fwd(rs2_execute, srcB_in);
    e.rd  = rd_execute;
    e.wre = wre_execute;
    e.wme = write_memory_enable_execute;
    e.sel = select_writeback_data_mux_execute;
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    exp_t obs;
    obs = {result_out, store_data_out, rd_out,
           wre_out, wme_out, wb_sel_out};
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(tag, 64'(obs), 64'(e));
    end
  endtask

  task automatic no_fwd();
    rd_memory        = 4'd0;
    wre_memory       = 1'b0;
    result_memory    = 16'h0;
    rd_writeback     = 4'd0;
    wre_writeback    = 1'b0;
    result_writeback = 16'h0;
  endtask

  task automatic set_op(input logic [3:0] op,
                        input logic [15:0] a, b,
                        input logic [3:0] r1, r2, rd,
                        input logic wre, wme,
                        input logic [1:0] sel);
    aluOp_execute                     = op;
    srcA_in                           = a;
    srcB_in                           = b;
    rs1_execute                       = r1;
    rs2_execute                       = r2;
    rd_execute                        = rd;
    wre_execute                       = wre;
    write_memory_enable_execute       = wme;
    select_writeback_data_mux_execute = sel;
  endtask

  task automatic run_single(input string tag,
                            input logic [15:0] res);
    #1;
    sb.push_back(issue_exp(res));
    check({tag, "_stall"}, 64'(stall_execute), 64'd0);
    tick();
    check_out(tag);
  endtask

  task automatic run_multi(input string tag,
                           input logic [15:0] res);
    int highs;
    #1;
    for (int i = 0; i < 16; i++) sb.push_back('0);
    sb.push_back(issue_exp(res));
    highs = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) #1;
      highs += int'(stall_execute);
      if (i == 16)
        check({tag, "_stall_last"}, 64'(stall_execute), 64'd0);
      tick();
      if (i == 0) begin
        // operands already captured: drain forwarding, disturb regs
        no_fwd();
        srcA_in = ~srcA_in;
        srcB_in = 16'h5A5A;
      end
      check_out(i == 16 ? {tag, "_result"} : {tag, "_bubble"});
    end
    check({tag, "_stall_cycles"}, 64'(highs), 64'd16);
  endtask

  initial begin
    reset = 1'b0;
    no_fwd();
    set_op(4'd10, 16'd300, 16'd200, 4'd1, 4'd2, 4'd5,
           1'b1, 1'b1, 2'd1);
    #1;
    check("reset_stall", 64'(stall_execute), 64'd0);
    tick();
    tick();
    sb.push_back('0);
    check_out("reset_outputs");
    set_op(4'd0, 16'h0005, 16'h0003, 4'd1, 4'd2, 4'd5,
           1'b1, 1'b0, 2'd0);
    reset = 1'b1;
    run_single("add", 16'h0008);

    set_op(4'd3, 16'hAAAA, 16'h0000, 4'd3, 4'd0, 4'd4,
           1'b1, 1'b0, 2'd0);
    rd_memory = 4'd3; wre_memory = 1'b1; result_memory = 16'h1111;
    rd_writeback = 4'd3; wre_writeback = 1'b1;
    result_writeback = 16'h2222;
    run_single("fwd_mem_prio", 16'h1111);
    rs1_execute = 4'd0; rd_memory = 4'd0; rd_writeback = 4'd0;
    run_single("fwd_r0", 16'hAAAA);
    no_fwd();

    set_op(4'd9, 16'h0000, 16'h0BAD, 4'd1, 4'd7, 4'd2,
           1'b1, 1'b1, 2'd2);
    rd_writeback = 4'd7; wre_writeback = 1'b1;
    result_writeback = 16'h2222;
    run_single("fwd_wb_b", 16'h2222);
    no_fwd();

    set_op(4'd1, 16'h0003, 16'h0005, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("sub_wrap", 16'hFFFE);
    set_op(4'd0, 16'hFFFF, 16'h0002, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("add_wrap", 16'h0001);
    set_op(4'd5, 16'h0001, 16'h0014, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("sll", 16'h0010);
    set_op(4'd6, 16'h8000, 16'h0004, 4'd1, 4'd2, 4'd3,
           1'b0, 1'b0, 2'd0);
    run_single("srl", 16'h0800);
    set_op(4'd7, 16'h8000, 16'h0004, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd3);
    run_single("sra", 16'hF800);
    set_op(4'd8, 16'hFFFF, 16'h0001, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("slt_true", 16'h0001);
    set_op(4'd8, 16'h0001, 16'hFFFF, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("slt_false", 16'h0000);
    set_op(4'd4, 16'hFF00, 16'h0FF0, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("xor", 16'hF0F0);
    set_op(4'd2, 16'hFF00, 16'h0FF0, 4'd1, 4'd2, 4'd3,
           1'b1, 1'b0, 2'd0);
    run_single("and", 16'h0F00);
    set_op(4'd14, 16'h1234, 16'h4321, 4'd1, 4'd2, 4'd9,
           1'b1, 1'b1, 2'd2);
    run_single("op14_zero", 16'h0000);

    set_op(4'd10, 16'd300, 16'd200, 4'd1, 4'd2, 4'd6,
           1'b1, 1'b0, 2'd1);
    run_multi("mul", 16'hEA60);
    set_op(4'd11, 16'd1000, 16'd7, 4'd1, 4'd2, 4'd7,
           1'b1, 1'b0, 2'd0);
    run_multi("div", 16'h008E);
    set_op(4'd12, 16'd1000, 16'd7, 4'd1, 4'd2, 4'd8,
           1'b1, 1'b1, 2'd0);
    run_multi("mod", 16'h0006);
    set_op(4'd11, 16'h1234, 16'h0000, 4'd1, 4'd2, 4'd7,
           1'b1, 1'b0, 2'd0);
    run_multi("div_zero", 16'hFFFF);
    set_op(4'd12, 16'h1234, 16'h0000, 4'd1, 4'd2, 4'd7,
           1'b1, 1'b0, 2'd0);
    run_multi("mod_zero", 16'h1234);

    set_op(4'd10, 16'd300, 16'd200, 4'd1, 4'd2, 4'd6,
           1'b1, 1'b0, 2'd1);
    #1;
    check("rst_mid_start_stall", 64'(stall_execute), 64'd1);
    for (int i = 0; i < 5; i++) begin
      sb.push_back('0);
      tick();
      check_out("rst_mid_bubble");
    end
    reset = 1'b0;
    #1;
    check("rst_mid_stall_comb", 64'(stall_execute), 64'd0);
    sb.push_back('0);
    tick();
    check_out("rst_mid_outputs");
    check("rst_mid_stall_after", 64'(stall_execute), 64'd0);
    set_op(4'd0, 16'h0010, 16'h0020, 4'd1, 4'd2, 4'd4,
           1'b1, 1'b0, 2'd0);
    reset = 1'b1;
    run_single("add_after_rst", 16'h0030);

    set_op(4'd10, 16'd300, 16'd200, 4'd1, 4'd2, 4'd6,
           1'b1, 1'b0, 2'd0);
    run_multi("b2b_mul", 16'hEA60);
    set_op(4'd11, 16'h0001, 16'h0010, 4'd6, 4'd2, 4'd7,
           1'b1, 1'b0, 2'd0);
    rd_memory = 4'd6; wre_memory = 1'b1; result_memory = 16'hEA60;
    run_multi("b2b_div", 16'h0EA6);
    set_op(4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0,
           1'b0, 1'b0, 2'd0);
    run_single("b2b_tail_bubble", 16'h0000);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit pipeline, directly downstream of the decode/execute pipeline register.
- Forwards operands from the memory and writeback stages and runs single-cycle ALU ops.
- Runs multi-cycle unsigned MUL/DIV/MOD on an iterative shift-add/restoring datapath.
- Registers results into the execute/memory boundary; asserts stall_execute to freeze upstream while a multi-cycle op is in flight.

Parameters:
DATA_W, 16, datapath width; iterative ops take DATA_W iterations
REG_W, 4, register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low (0 = reset)
aluOp_execute  in  4  ALU operation code
srcA_in  in  DATA_W  register-file operand A
srcB_in  in  DATA_W  register-file operand B
rs1_execute  in  REG_W  source register of A
rs2_execute  in  REG_W  source register of B
rd_execute  in  REG_W  destination register
wre_execute  in  1  register write enable
write_memory_enable_execute  in  1  memory write enable
select_writeback_data_mux_execute  in  2  writeback source select
rd_memory  in  REG_W  memory-stage destination
wre_memory  in  1  memory-stage write enable
result_memory  in  DATA_W  memory-stage ALU result
rd_writeback  in  REG_W  writeback-stage destination
wre_writeback  in  1  writeback-stage write enable
result_writeback  in  DATA_W  writeback data
stall_execute  out  1  hold decode/execute register and earlier stages
result_out  out  DATA_W  registered ALU result
store_data_out  out  DATA_W  registered forwarded operand B
rd_out  out  REG_W  registered destination
wre_out  out  1  registered register write enable
wme_out  out  1  registered memory write enable
wb_sel_out  out  2  registered writeback select

Behaviour:
- Reset (reset==0 at posedge): all registered outputs 0, FSM to IDLE, counter 0; stall_execute 0 combinationally while reset is low. Applies mid-operation and discards the partial result.
- Forwarding, per operand, combinational:
  - Memory stage has priority: use result_memory when wre_memory=1, rd_memory!=0 and rd_memory equals the rs.
  - Otherwise writeback: same rule using rd_writeback, wre_writeback and result_writeback.
  - Otherwise the register-file value.
  - Register 0 is never forwarded.
- Single-cycle ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 PASSB.
  - Shift amount = B[3:0]. SLT is signed and yields 1 or 0.
  - ADD/SUB wrap modulo 2^16.
  - Codes 13-15 give result 0 with the control bits passed through unchanged.
  - In IDLE, every posedge registers result and control fields with 1-cycle latency.
- Multi-cycle ops: 10 MUL (low 16 bits of the product), 11 DIV (quotient), 12 MOD (remainder); all unsigned. Start is decided by aluOp alone; the bubble's aluOp=0 never starts one.
- FSM IDLE -> BUSY -> IDLE. With the op presented at cycle T:
  - T, IDLE: stall_execute=1. Forwarded operands latched. Counter cleared. Output register loads a bubble (wre_out=0, wme_out=0, other fields 0). Next state BUSY.
  - T+1..T+16, BUSY: one iteration per cycle; counter runs 0..15. Inputs ignored; operands are already captured, so drained forwarding sources are not needed.
  - stall_execute=1 on T+1..T+15 and 0 on T+16. The decode/execute register advances at the T+16 edge.
  - Bubbles are registered on T+1..T+15.
  - Final iteration on T+16: result plus the captured rd, wre, wme and wb_sel are registered. They are visible at T+17. Next state IDLE.
- Divide by zero: quotient 0xFFFF, remainder = dividend. Takes the same 16-cycle timing.
- A multi-cycle op immediately following another starts normally in the IDLE cycle after completion.
- store_data_out is the forwarded B latched at accept time.

Decomposition:
- Package execute_pkg holds:
  - alu_op_t enum with codes 0-12.
  - Constants ALU_MUL, ALU_DIV, ALU_MOD.
  - ex_state_t {IDLE, BUSY}.
  - Function is_multicycle(op).
- One sub-module, muldiv_iter: start, op, a, b in; iteration counter and done out; owns the shift-add and restoring datapath.
- Forwarding muxes and the single-cycle ALU stay inline.

Test Plan:
- ADD, A=0x0005, B=0x0003, no hazards -> result_out=0x0008 one cycle later, wre_out follows wre_execute.
- rs1=3 with rd_memory=3 (wre_memory=1, result 0x1111) and rd_writeback=3 (wre_writeback=1, 0x2222) -> memory value 0x1111 used. The same case with rs1=0 -> register-file value used.
- MUL 300*200 -> stall_execute high for exactly 16 cycles; result_out=0xEA60 at T+17; bubbles (wre_out=0) on T+1..T+16.
- DIV 1000/7 -> 0x008E; MOD 1000/7 -> 0x0006; DIV 0x1234/0 -> 0xFFFF; MOD 0x1234/0 -> 0x1234.
- reset=0 at T+5 of a MUL -> outputs 0 and stall 0 the next cycle; an ADD after release completes in 1 cycle.
- Back-to-back MUL then DIV, with DIV's rs1 equal to MUL's rd forwarded via result_memory -> correct quotient and no duplicate issue of the MUL.
